// File: rtl/popcount_pkg.sv
// Shared types and constants for the unary (count -> vector) generator.
// Holds the FSM state encoding, the default width and the LFSR feedback taps.
package popcount_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUILD = 2'd1,
        HOLD  = 2'd2
    } gen_state_e;

    localparam int N_DEFAULT = 9;

    // Feedback taps 16,14,13,11 of a 16-stage Fibonacci register (stage 16 = bit 15)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int clog2_cnt(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/popcount_lfsr16.sv
// 16-bit Fibonacci LFSR that scatters ones in the generated vector.
// Only compiled when UNARY_GEN_SHUFFLE_EN is defined, since nothing else uses it.
`ifdef UNARY_GEN_SHUFFLE_EN
module popcount_lfsr16
    import popcount_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic lfsr_bit
);

    logic [15:0] lfsr_r;
    logic        fb_s;

    assign fb_s     = ^(lfsr_r & LFSR_TAPS);
    assign lfsr_bit = lfsr_r[0];

    // Shift register: advances only while enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r <= SEED;
        end else if (en) begin
            lfsr_r <= {lfsr_r[14:0], fb_s};
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

endmodule
`endif

// File: rtl/popcount_unary_gen.sv
// Builds an N-bit vector with exactly min(cnt_data,N) ones, one slot per clock.
// Thermometer output by default; UNARY_GEN_SHUFFLE_EN scatters the ones with an LFSR.
module popcount_unary_gen
    import popcount_pkg::*;
#(
    parameter int          N         = N_DEFAULT,
    parameter int          CW        = clog2_cnt(N),
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cnt_valid,
    output logic          cnt_ready,
    input  logic [CW-1:0] cnt_data,
    output logic          vec_valid,
    input  logic          vec_ready,
    output logic [N-1:0]  vec_data,
    output logic          vec_sat
);

    localparam logic [CW-1:0] N_C    = CW'(N);
    localparam logic [CW-1:0] LAST_C = CW'(N - 1);

    gen_state_e    state_r, state_n;
    logic [CW-1:0] slot_r, slot_n;
    logic [CW-1:0] ones_r, ones_n;
    logic [N-1:0]  vec_data_r, vec_data_n;
    logic          vec_sat_r, vec_sat_n;
    logic          vec_valid_r, vec_valid_n;
    logic          cnt_ready_r, cnt_ready_n;
    logic          bit_s;

`ifdef UNARY_GEN_SHUFFLE_EN
    logic [CW-1:0] rem_r, rem_n;
    logic          lfsr_bit_s;
    logic          build_s;

    assign build_s = (state_r == BUILD);

    popcount_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (build_s),
        .lfsr_bit (lfsr_bit_s)
    );

    // A one is forced when the remaining ones exactly fill the remaining slots
    assign bit_s = (ones_r != {CW{1'b0}}) && ((ones_r == rem_r) || lfsr_bit_s);
`else
    logic unused_seed_s;

    assign unused_seed_s = ^LFSR_SEED;
    assign bit_s         = (ones_r != {CW{1'b0}});
`endif

    assign cnt_ready = cnt_ready_r;
    assign vec_valid = vec_valid_r;
    assign vec_data  = vec_data_r;
    assign vec_sat   = vec_sat_r;

    // FSM state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            slot_r      <= {CW{1'b0}};
            ones_r      <= {CW{1'b0}};
            vec_data_r  <= {N{1'b0}};
            vec_sat_r   <= 1'b0;
            vec_valid_r <= 1'b0;
            cnt_ready_r <= 1'b1;
`ifdef UNARY_GEN_SHUFFLE_EN
            rem_r       <= {CW{1'b0}};
`endif
        end else begin
            state_r     <= state_n;
            slot_r      <= slot_n;
            ones_r      <= ones_n;
            vec_data_r  <= vec_data_n;
            vec_sat_r   <= vec_sat_n;
            vec_valid_r <= vec_valid_n;
            cnt_ready_r <= cnt_ready_n;
`ifdef UNARY_GEN_SHUFFLE_EN
            rem_r       <= rem_n;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n     = state_r;
        slot_n      = slot_r;
        ones_n      = ones_r;
        vec_data_n  = vec_data_r;
        vec_sat_n   = vec_sat_r;
        vec_valid_n = vec_valid_r;
        cnt_ready_n = cnt_ready_r;
`ifdef UNARY_GEN_SHUFFLE_EN
        rem_n       = rem_r;
`endif
        case (state_r)
            IDLE: begin
                if (cnt_valid && cnt_ready_r) begin
                    ones_n      = (cnt_data > N_C) ? N_C : cnt_data;
                    vec_sat_n   = (cnt_data > N_C);
                    slot_n      = {CW{1'b0}};
                    vec_data_n  = {N{1'b0}};
                    cnt_ready_n = 1'b0;
                    state_n     = BUILD;
`ifdef UNARY_GEN_SHUFFLE_EN
                    rem_n       = N_C;
`endif
                end else begin
                    cnt_ready_n = 1'b1;
                end
            end
            BUILD: begin
                for (int i = 0; i < N; i++) begin
                    if (slot_r == CW'(i)) begin
                        vec_data_n[i] = bit_s;
                    end else begin
                        vec_data_n[i] = vec_data_r[i];
                    end
                end
                // bit_s is zero once ones_r reaches zero, so this never wraps
                if (bit_s) begin
                    ones_n = ones_r - {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    ones_n = ones_r;
                end
                slot_n = slot_r + {{(CW-1){1'b0}}, 1'b1};
`ifdef UNARY_GEN_SHUFFLE_EN
                rem_n  = rem_r - {{(CW-1){1'b0}}, 1'b1};
`endif
                if (slot_r == LAST_C) begin
                    state_n     = HOLD;
                    vec_valid_n = 1'b1;
                end else begin
                    state_n     = BUILD;
                end
            end
            HOLD: begin
                if (vec_ready) begin
                    state_n     = IDLE;
                    vec_valid_n = 1'b0;
                    cnt_ready_n = 1'b1;
                end else begin
                    state_n     = HOLD;
                end
            end
            default: begin
                state_n     = IDLE;
                vec_valid_n = 1'b0;
                cnt_ready_n = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_popcount_unary_gen.sv
// Directed bench for popcount_unary_gen: table of counts plus stall, throughput and reset sequences.
// With UNARY_GEN_SHUFFLE_EN defined, vectors are checked by popcount and a random sweep is added.
module tb_popcount_unary_gen;

    localparam int N  = 9;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cnt_valid = 1'b0;
    logic          cnt_ready;
    logic [CW-1:0] cnt_data = 4'd0;
    logic          vec_valid;
    logic          vec_ready = 1'b0;
    logic [N-1:0]  vec_data;
    logic          vec_sat;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [CW-1:0] cnt;
        logic [N-1:0]  vec;
        logic          sat;
    } vec_rec_t;

    vec_rec_t tbl[13];

    popcount_unary_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cnt_valid (cnt_valid),
        .cnt_ready (cnt_ready),
        .cnt_data  (cnt_data),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .vec_data  (vec_data),
        .vec_sat   (vec_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Vector check: exact pattern for thermometer, popcount for shuffled builds
    task automatic check_vec(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
`ifdef UNARY_GEN_SHUFFLE_EN
        check(name, $countones(got), $countones(exp));
`else
        check(name, {23'd0, got}, {23'd0, exp});
`endif
    endtask

    // Issue a count and wait for vec_valid; lat counts clock edges including the accept edge
    task automatic run_vec(input logic [CW-1:0] c, output logic [N-1:0] v, output logic s, output int lat);
        @(negedge clk);
        cnt_data  = c;
        cnt_valid = 1'b1;
        vec_ready = 1'b0;
        @(posedge clk);
        #1;
        cnt_valid = 1'b0;
        cnt_data  = ~c;
        lat = 1;
        while (vec_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        v = vec_data;
        s = vec_sat;
    endtask

    task automatic handoff();
        @(negedge clk);
        vec_ready = 1'b1;
        @(posedge clk);
        #1;
        vec_ready = 1'b0;
        check("handoff_valid_low", {31'd0, vec_valid}, 32'd0);
        check("handoff_ready_high", {31'd0, cnt_ready}, 32'd1);
    endtask

    initial begin
        logic [N-1:0] v;
        logic         s;
        int           lat;
        int           bad;
        int           highs;
        int           p0;
        int           p1;
        int           nonthermo;

        for (int i = 0; i <= 9; i++) begin
            tbl[i].cnt = CW'(i);
            tbl[i].sat = 1'b0;
        end
        tbl[0].vec = 9'h000; tbl[1].vec = 9'h001; tbl[2].vec = 9'h003;
        tbl[3].vec = 9'h007; tbl[4].vec = 9'h00F; tbl[5].vec = 9'h01F;
        tbl[6].vec = 9'h03F; tbl[7].vec = 9'h07F; tbl[8].vec = 9'h0FF;
        tbl[9].vec = 9'h1FF;
        tbl[10] = '{cnt: 4'd10, vec: 9'h1FF, sat: 1'b1};
        tbl[11] = '{cnt: 4'd12, vec: 9'h1FF, sat: 1'b1};
        tbl[12] = '{cnt: 4'd15, vec: 9'h1FF, sat: 1'b1};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_cnt_ready", {31'd0, cnt_ready}, 32'd1);
        check("rst_vec_valid", {31'd0, vec_valid}, 32'd0);
        check("rst_vec_data", {23'd0, vec_data}, 32'd0);
        check("rst_vec_sat", {31'd0, vec_sat}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Count zero: full-length build with no ones
        run_vec(4'd0, v, s, lat);
        check("zero_latency", lat, 32'd10);
        check("zero_vec", {23'd0, v}, 32'd0);
        check("zero_sat", {31'd0, s}, 32'd0);
        handoff();

        // Table sweep including saturation
        for (int i = 0; i < 13; i++) begin
            run_vec(tbl[i].cnt, v, s, lat);
            check("tbl_latency", lat, 32'd10);
            check_vec("tbl_vec", v, tbl[i].vec);
            check("tbl_sat", {31'd0, s}, {31'd0, tbl[i].sat});
            handoff();
        end

        // Stall in HOLD for 20 clocks
        run_vec(4'd6, v, s, lat);
        check_vec("stall_vec", v, 9'h03F);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (vec_valid !== 1'b1 || vec_data !== v || vec_sat !== s || cnt_ready !== 1'b0) bad++;
        end
        check("stall_stable", bad, 32'd0);
        handoff();

        // Throughput with both sides always ready: one vector every N+2 clocks
        @(negedge clk);
        cnt_data  = 4'd4;
        cnt_valid = 1'b1;
        vec_ready = 1'b1;
        highs = 0;
        p0 = -1;
        p1 = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (vec_valid === 1'b1) begin
                highs++;
                if (p0 < 0) p0 = k;
                else if (p1 < 0) p1 = k;
            end
        end
        check("thru_pulses", highs, 32'd3);
        check("thru_period", p1 - p0, 32'd11);
        cnt_valid = 1'b0;
        repeat (15) @(negedge clk);
        vec_ready = 1'b0;
        check("thru_drain_idle", {31'd0, cnt_ready}, 32'd1);

        // Reset during BUILD slot 4 discards the partial vector
        @(negedge clk);
        cnt_data  = 4'd7;
        cnt_valid = 1'b1;
        @(posedge clk);
        #1;
        cnt_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_cnt_ready", {31'd0, cnt_ready}, 32'd1);
        check("midrst_vec_valid", {31'd0, vec_valid}, 32'd0);
        check("midrst_vec_data", {23'd0, vec_data}, 32'd0);
        check("midrst_vec_sat", {31'd0, vec_sat}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (vec_valid !== 1'b0) bad++;
        end
        check("midrst_no_valid", bad, 32'd0);
        run_vec(4'd5, v, s, lat);
        check("post_rst_latency", lat, 32'd10);
        check_vec("post_rst_vec", v, 9'h01F);
        check("post_rst_sat", {31'd0, s}, 32'd0);
        handoff();

`ifdef UNARY_GEN_SHUFFLE_EN
        // Random counts: exact popcount, and at least some non-thermometer patterns
        nonthermo = 0;
        for (int k = 0; k < 1000; k++) begin
            int c;
            logic [N-1:0] thermo;
            c = $urandom_range(0, 9);
            thermo = 9'h000;
            for (int b = 0; b < c; b++) thermo[b] = 1'b1;
            run_vec(CW'(c), v, s, lat);
            check("shuf_popcount", $countones(v), c);
            if (v !== thermo) nonthermo++;
            handoff();
        end
        check("shuf_scatter", {31'd0, (nonthermo != 0)}, 32'd1);
`else
        nonthermo = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
